// File: rtl/spc_ckpt_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spc_ckpt_ctrl
// Supervisor sitting on the far side of the SoC fault-tolerance interface.
// It boots the core, periodically asks for a safe-PC snapshot (signal_o pulse,
// then captures spc_i), relaunches the core from the last good checkpoint on a
// fault, and latches the program result once mem_flag_i goes nonzero.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              allows the initial boot to proceed
//   fault_i               fault level, sampled every cycle
//   mem_flag_i            SoC completion flag (nonzero = done)
//   mem_result_i          SoC result word
//   spc_i                 safe PC reported by the SoC
//   signal_o              one-cycle checkpoint request
//   core_rst_no           active-low core reset
//   fetch_en_o            core fetch enable
//   boot_addr_o           core (re)start address
//   ckpt_valid_o          at least one checkpoint captured
//   ckpt_pc_o             last captured safe PC
//   ckpt_count_o          checkpoints captured (saturating)
//   recover_count_o       restores performed (saturating)
//   done_o, result_o      sticky completion flag and latched result
//   fail_o                sticky recovery-budget-exhausted flag
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spc_ckpt_ctrl #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0080,
  parameter int          CKPT_PERIOD = 64,
  parameter int          SPC_LAT     = 2,
  parameter int          RST_HOLD    = 4,
  parameter int          MAX_RECOVER = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        fault_i,
  input  logic [31:0] mem_flag_i,
  input  logic [31:0] mem_result_i,
  input  logic [31:0] spc_i,
  output logic        signal_o,
  output logic        core_rst_no,
  output logic        fetch_en_o,
  output logic [31:0] boot_addr_o,
  output logic        ckpt_valid_o,
  output logic [31:0] ckpt_pc_o,
  output logic [15:0] ckpt_count_o,
  output logic [7:0]  recover_count_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        fail_o
);

  // +1 keeps every counter at least one bit wide when a parameter is 1.
  localparam int PW = $clog2(CKPT_PERIOD + 1);
  localparam int LW = $clog2(SPC_LAT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESTORE = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] period_q, period_d;
  logic [LW-1:0] lat_q, lat_d;
  logic        signal_q, signal_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        fetch_en_q, fetch_en_d;
  logic [31:0] boot_addr_q, boot_addr_d;
  logic        ckpt_valid_q, ckpt_valid_d;
  logic [31:0] ckpt_pc_q, ckpt_pc_d;
  logic [15:0] ckpt_count_q, ckpt_count_d;
  logic [7:0]  recover_q, recover_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        fail_q, fail_d;

  logic        start_restore_s;
  logic [7:0]  recover_inc_s;

  // Next-state and next-output logic for the supervisor FSM.
  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    period_d        = period_q;
    lat_d           = lat_q;
    signal_d        = 1'b0;
    core_rst_n_d    = core_rst_n_q;
    fetch_en_d      = fetch_en_q;
    boot_addr_d     = boot_addr_q;
    ckpt_valid_d    = ckpt_valid_q;
    ckpt_pc_d       = ckpt_pc_q;
    ckpt_count_d    = ckpt_count_q;
    recover_d       = recover_q;
    done_d          = done_q;
    result_d        = result_q;
    fail_d          = fail_q;
    start_restore_s = 1'b0;
    recover_inc_s   = (recover_q == 8'hFF) ? 8'hFF : (recover_q + 8'd1);

    case (state_q)
      ST_BOOT: begin
        // The boot hold only makes progress while the system enables us.
        if (enable_i) begin
          if (hold_q == HW'(RST_HOLD - 1)) begin
            state_d      = ST_RUN;
            hold_d       = '0;
            core_rst_n_d = 1'b1;
            fetch_en_d   = 1'b1;
            period_d     = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          hold_d = hold_q;
        end
      end

      ST_RUN: begin
        if (fault_i) begin
          start_restore_s = 1'b1;
        end else if (mem_flag_i != 32'd0) begin
          state_d    = ST_DONE;
          result_d   = mem_result_i;
          done_d     = 1'b1;
          fetch_en_d = 1'b0;
        end else if (period_q == PW'(CKPT_PERIOD - 1)) begin
          state_d  = ST_REQ;
          period_d = '0;
          signal_d = 1'b1;
        end else begin
          period_d = period_q + PW'(1);
        end
      end

      ST_REQ: begin
        if (fault_i) begin
          start_restore_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
          lat_d   = '0;
        end
      end

      ST_WAIT: begin
        // mem_flag_i is deliberately not looked at here: the capture always
        // completes and completion is then picked up from RUN.
        if (fault_i) begin
          start_restore_s = 1'b1;
        end else if (lat_q == LW'(SPC_LAT - 1)) begin
          state_d      = ST_RUN;
          ckpt_pc_d    = spc_i;
          ckpt_valid_d = 1'b1;
          ckpt_count_d = (ckpt_count_q == 16'hFFFF) ? 16'hFFFF : (ckpt_count_q + 16'd1);
          period_d     = '0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      ST_RESTORE: begin
        // Faults during the hold are ignored and do not restart it.
        if (hold_q == HW'(RST_HOLD - 1)) begin
          state_d      = ST_RUN;
          hold_d       = '0;
          core_rst_n_d = 1'b1;
          fetch_en_d   = 1'b1;
          period_d     = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        // Unreachable encoding: park the core in reset and reboot.
        state_d      = ST_BOOT;
        hold_d       = '0;
        core_rst_n_d = 1'b0;
        fetch_en_d   = 1'b0;
      end
    endcase

    // Shared RESTORE entry, taken from RUN, REQ or WAIT.
    if (start_restore_s) begin
      recover_d    = recover_inc_s;
      boot_addr_d  = ckpt_valid_q ? ckpt_pc_q : BOOT_ADDR;
      core_rst_n_d = 1'b0;
      fetch_en_d   = 1'b0;
      hold_d       = '0;
      if (recover_inc_s > 8'(MAX_RECOVER)) begin
        state_d = ST_FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = ST_RESTORE;
      end
    end else begin
      recover_d = recover_d;
    end
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      hold_q       <= '0;
      period_q     <= '0;
      lat_q        <= '0;
      signal_q     <= 1'b0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      boot_addr_q  <= BOOT_ADDR;
      ckpt_valid_q <= 1'b0;
      ckpt_pc_q    <= BOOT_ADDR;
      ckpt_count_q <= 16'd0;
      recover_q    <= 8'd0;
      done_q       <= 1'b0;
      result_q     <= 32'd0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      period_q     <= period_d;
      lat_q        <= lat_d;
      signal_q     <= signal_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      boot_addr_q  <= boot_addr_d;
      ckpt_valid_q <= ckpt_valid_d;
      ckpt_pc_q    <= ckpt_pc_d;
      ckpt_count_q <= ckpt_count_d;
      recover_q    <= recover_d;
      done_q       <= done_d;
      result_q     <= result_d;
      fail_q       <= fail_d;
    end
  end

  assign signal_o        = signal_q;
  assign core_rst_no     = core_rst_n_q;
  assign fetch_en_o      = fetch_en_q;
  assign boot_addr_o     = boot_addr_q;
  assign ckpt_valid_o    = ckpt_valid_q;
  assign ckpt_pc_o       = ckpt_pc_q;
  assign ckpt_count_o    = ckpt_count_q;
  assign recover_count_o = recover_q;
  assign done_o          = done_q;
  assign result_o        = result_q;
  assign fail_o          = fail_q;

endmodule

// File: tb/tb_spc_ckpt_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spc_ckpt_ctrl
// Directed bench for spc_ckpt_ctrl with default parameters. Inputs are driven
// and outputs sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_spc_ckpt_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        fault_i;
  logic [31:0] mem_flag_i;
  logic [31:0] mem_result_i;
  logic [31:0] spc_i;
  logic        signal_o;
  logic        core_rst_no;
  logic        fetch_en_o;
  logic [31:0] boot_addr_o;
  logic        ckpt_valid_o;
  logic [31:0] ckpt_pc_o;
  logic [15:0] ckpt_count_o;
  logic [7:0]  recover_count_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        fail_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc;

  spc_ckpt_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .fault_i         (fault_i),
    .mem_flag_i      (mem_flag_i),
    .mem_result_i    (mem_result_i),
    .spc_i           (spc_i),
    .signal_o        (signal_o),
    .core_rst_no     (core_rst_no),
    .fetch_en_o      (fetch_en_o),
    .boot_addr_o     (boot_addr_o),
    .ckpt_valid_o    (ckpt_valid_o),
    .ckpt_pc_o       (ckpt_pc_o),
    .ckpt_count_o    (ckpt_count_o),
    .recover_count_o (recover_count_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .fail_o          (fail_o)
  );

  // 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Count cycles until signal_o rises, capped at a budget.
  task automatic wait_pulse(input int start, output int cnt);
    cnt = start;
    while (signal_o !== 1'b1 && cnt < 200) begin
      step(1);
      cnt++;
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; fault_i = 1'b0;
    mem_flag_i = 32'd0; mem_result_i = 32'd0; spc_i = 32'h0000_01A4;
    step(3);
    rst_i = 1'b0;

    // Reset values.
    check_value("rst_core_rst_no", {31'd0, core_rst_no}, 32'd0);
    check_value("rst_fetch_en", {31'd0, fetch_en_o}, 32'd0);
    check_value("rst_signal", {31'd0, signal_o}, 32'd0);
    check_value("rst_boot_addr", boot_addr_o, 32'h0000_0080);
    check_value("rst_ckpt_pc", ckpt_pc_o, 32'h0000_0080);
    check_value("rst_ckpt_valid", {31'd0, ckpt_valid_o}, 32'd0);
    check_value("rst_ckpt_count", {16'd0, ckpt_count_o}, 32'd0);
    check_value("rst_recover", {24'd0, recover_count_o}, 32'd0);
    check_value("rst_done_fail", {30'd0, done_o, fail_o}, 32'd0);
    check_value("rst_result", result_o, 32'd0);

    // enable_i low keeps BOOT.
    step(10);
    check_value("boot_hold_no_enable", {31'd0, core_rst_no}, 32'd0);

    // Boot: four enabled cycles of reset hold.
    enable_i = 1'b1;
    step(3);
    check_value("boot_still_held", {31'd0, core_rst_no}, 32'd0);
    step(1);
    check_value("boot_release", {30'd0, core_rst_no, fetch_en_o}, 32'd3);

    // First checkpoint pulse 64 cycles into RUN.
    wait_pulse(0, n_cyc);
    check_value("first_pulse_dist", n_cyc, 32'd64);
    step(1);
    check_value("pulse_one_cycle", {31'd0, signal_o}, 32'd0);
    check_value("ckpt_not_yet", {16'd0, ckpt_count_o}, 32'd0);
    step(2);
    check_value("ckpt_pc", ckpt_pc_o, 32'h0000_01A4);
    check_value("ckpt_count1", {16'd0, ckpt_count_o}, 32'd1);
    check_value("ckpt_valid", {31'd0, ckpt_valid_o}, 32'd1);
    wait_pulse(3, n_cyc);
    check_value("second_pulse_dist", n_cyc, 32'd67);

    // Fault in the cycle after the pulse aborts the capture.
    spc_i = 32'h0000_0200;
    step(1);
    fault_i = 1'b1;
    step(1);
    fault_i = 1'b0;
    check_value("abort_ckpt_pc", ckpt_pc_o, 32'h0000_01A4);
    check_value("abort_ckpt_count", {16'd0, ckpt_count_o}, 32'd1);
    check_value("abort_recover", {24'd0, recover_count_o}, 32'd1);
    check_value("abort_boot_addr", boot_addr_o, 32'h0000_01A4);
    check_value("abort_core_rst", {30'd0, core_rst_no, fetch_en_o}, 32'd0);
    step(3);
    check_value("restore_hold", {31'd0, core_rst_no}, 32'd0);
    step(1);
    check_value("restore_release", {30'd0, core_rst_no, fetch_en_o}, 32'd3);

    // Fault pulse in RUN.
    step(5);
    fault_i = 1'b1;
    step(1);
    fault_i = 1'b0;
    check_value("run_fault_recover", {24'd0, recover_count_o}, 32'd2);
    check_value("run_fault_core_rst", {31'd0, core_rst_no}, 32'd0);
    step(4);
    check_value("run_fault_release", {31'd0, core_rst_no}, 32'd1);

    // Third fault: still within budget.
    step(5);
    fault_i = 1'b1;
    step(1);
    fault_i = 1'b0;
    check_value("third_recover", {24'd0, recover_count_o}, 32'd3);
    check_value("third_not_fail", {31'd0, fail_o}, 32'd0);
    step(4);
    check_value("third_release", {31'd0, core_rst_no}, 32'd1);

    // Fourth fault exhausts the budget.
    step(5);
    fault_i = 1'b1;
    step(1);
    fault_i = 1'b0;
    check_value("fail_set", {31'd0, fail_o}, 32'd1);
    check_value("fail_recover", {24'd0, recover_count_o}, 32'd4);
    step(10);
    check_value("fail_sticky", {30'd0, fail_o, core_rst_no}, 32'd2);
    check_value("fail_fetch", {31'd0, fetch_en_o}, 32'd0);

    // Reset clears everything; enable_i stays high.
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check_value("rst2_fail", {31'd0, fail_o}, 32'd0);
    check_value("rst2_recover", {24'd0, recover_count_o}, 32'd0);
    check_value("rst2_ckpt_count", {16'd0, ckpt_count_o}, 32'd0);
    check_value("rst2_ckpt_valid", {31'd0, ckpt_valid_o}, 32'd0);
    check_value("rst2_ckpt_pc", ckpt_pc_o, 32'h0000_0080);
    check_value("rst2_boot_addr", boot_addr_o, 32'h0000_0080);
    step(4);
    check_value("reboot_release", {31'd0, core_rst_no}, 32'd1);

    // Fault with no checkpoint, held through the restore hold.
    step(3);
    fault_i = 1'b1;
    step(1);
    check_value("nockpt_boot_addr", boot_addr_o, 32'h0000_0080);
    check_value("nockpt_recover", {24'd0, recover_count_o}, 32'd1);
    step(4);
    check_value("held_fault_ignored", {24'd0, recover_count_o}, 32'd1);
    check_value("held_fault_release", {31'd0, core_rst_no}, 32'd1);
    step(1);
    fault_i = 1'b0;
    check_value("held_fault_rerestore", {24'd0, recover_count_o}, 32'd2);
    check_value("held_fault_core_rst", {31'd0, core_rst_no}, 32'd0);
    step(4);

    // Fault and completion together: RESTORE wins.
    fault_i = 1'b1;
    mem_flag_i = 32'd1;
    mem_result_i = 32'd55;
    step(1);
    fault_i = 1'b0;
    mem_flag_i = 32'd0;
    check_value("tie_done", {31'd0, done_o}, 32'd0);
    check_value("tie_recover", {24'd0, recover_count_o}, 32'd3);
    step(4);

    // Completion.
    mem_flag_i = 32'd1;
    step(1);
    mem_flag_i = 32'd0;
    check_value("done_set", {31'd0, done_o}, 32'd1);
    check_value("done_result", result_o, 32'd55);
    check_value("done_core", {30'd0, core_rst_no, fetch_en_o}, 32'd2);
    fault_i = 1'b1;
    mem_result_i = 32'd99;
    step(3);
    fault_i = 1'b0;
    check_value("done_fault_ignored", {24'd0, recover_count_o}, 32'd3);
    check_value("done_sticky", {30'd0, done_o, fail_o}, 32'd2);
    check_value("done_result_kept", result_o, 32'd55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spc_ckpt_ctrl.md
Name: spc_ckpt_ctrl

Overview:
- Supervisor on the far side of the zeroriscy_soc fault-tolerance interface.
- Boots the core and periodically requests a safe-PC snapshot by pulsing `signal`, then captures `spc_o`.
- On a fault, holds the core in reset and relaunches it from the last good checkpoint.
- Watches `mem_flag` for program completion and latches `mem_result`.

Parameters:
- BOOT_ADDR, 32'h0000_0080, boot address when no checkpoint is valid.
- CKPT_PERIOD, 64, RUN cycles between checkpoint requests (≥2).
- SPC_LAT, 2, cycles from the signal_o pulse to a valid spc_i (≥1).
- RST_HOLD, 4, cycles core_rst_no is held low per boot/restore (≥1).
- MAX_RECOVER, 3, restores allowed before FAIL (1..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  permits leaving BOOT
- fault_i  in  1  fault detected, level sampled each cycle
- mem_flag_i  in  32  SoC completion flag; nonzero = done
- mem_result_i  in  32  SoC result word
- spc_i  in  32  safe PC from SoC (spc_o)
- signal_o  out  1  checkpoint request to SoC, one-cycle pulse
- core_rst_no  out  1  active-low core reset
- fetch_en_o  out  1  core fetch enable
- boot_addr_o  out  32  core restart address
- ckpt_valid_o  out  1  a checkpoint has been captured
- ckpt_pc_o  out  32  last captured safe PC
- ckpt_count_o  out  16  checkpoints captured, saturating
- recover_count_o  out  8  restores performed, saturating
- done_o  out  1  program completed, sticky
- result_o  out  32  latched mem_result_i
- fail_o  out  1  recovery budget exhausted, sticky

Behaviour:
- Reset (rst_i=1 at a clk_i edge) values:
  - state=BOOT; signal_o=0; core_rst_no=0; fetch_en_o=0; boot_addr_o=BOOT_ADDR.
  - ckpt_valid_o=0; ckpt_pc_o=BOOT_ADDR; all counters 0; done_o=0; result_o=0; fail_o=0.
  - rst_i mid-operation aborts any state with the same values.
- Outputs are registered. The state decides an output in the cycle after the transition.
- BOOT:
  - core_rst_no=0, fetch_en_o=0.
  - The hold counter counts RST_HOLD cycles but only advances while enable_i=1.
  - When the count completes: core_rst_no=1, fetch_en_o=1, period counter cleared, go to RUN.
- RUN priority, evaluated each cycle: fault_i > mem_flag_i!=0 > period expiry.
  - Period counter increments. At CKPT_PERIOD-1 it goes to REQ and clears.
- REQ: signal_o=1 for exactly one cycle, latency counter cleared, go to WAIT.
- WAIT:
  - After SPC_LAT cycles (counting from the cycle after the pulse), sample spc_i into ckpt_pc_o.
  - Set ckpt_valid_o=1, ckpt_count_o+1 (saturate at 16'hFFFF), go to RUN.
  - mem_flag_i nonzero in REQ/WAIT: finish the capture first, then DONE is taken from RUN.
- Fault in REQ or WAIT: abort with no checkpoint update (ckpt_pc_o and count unchanged), go to RESTORE.
- RESTORE entry:
  - recover_count_o+1 (saturate at 255).
  - boot_addr_o = ckpt_valid_o ? ckpt_pc_o : BOOT_ADDR.
  - core_rst_no=0, fetch_en_o=0, hold counter cleared.
  - If the incremented count exceeds MAX_RECOVER, go to FAIL instead.
- RESTORE hold:
  - After RST_HOLD cycles: core_rst_no=1, fetch_en_o=1, period counter cleared, go to RUN. enable_i is ignored here.
  - fault_i asserted during the hold is ignored; the hold is not restarted.
  - fault_i still high on the first RUN cycle triggers another RESTORE.
- DONE:
  - On entry, result_o=mem_result_i, done_o=1, fetch_en_o=0; core_rst_no stays 1.
  - Terminal until rst_i. fault_i and mem_flag_i are ignored.
- FAIL: core_rst_no=0, fetch_en_o=0, fail_o=1. Terminal until rst_i.
- signal_o is never high outside REQ. Back-to-back checkpoints are at least CKPT_PERIOD+SPC_LAT+1 cycles apart.
- boot_addr_o changes only at reset and on RESTORE entry.

Test Plan:
- Boot: rst_i high 3 cycles, enable_i=1, defaults → core_rst_no low 4 cycles after reset release, then core_rst_no=1 and fetch_en_o=1. enable_i=0 holds BOOT indefinitely.
- Checkpoint: run with spc_i=32'h0000_01A4 → first signal_o pulse 64 RUN cycles after boot. ckpt_pc_o=32'h1A4 and ckpt_count_o=1 two cycles after the pulse. Next pulse exactly 67 cycles after the first.
- Restore: one checkpoint at 32'h1A4, then fault_i for 1 cycle → core_rst_no low 4 cycles, boot_addr_o=32'h1A4, recover_count_o=1, then RUN. A fault before any checkpoint gives boot_addr_o=32'h80.
- Fault mid-capture: fault_i in the cycle after the signal_o pulse with spc_i=32'h200 → ckpt_pc_o keeps its old value, ckpt_count_o unchanged, recover_count_o increments.
- Completion: mem_flag_i=1, mem_result_i=55 in RUN → done_o=1, result_o=55, fetch_en_o=0. A later fault_i has no effect. mem_flag_i and fault_i in the same cycle → RESTORE wins, done_o stays 0.
- Exhaustion: 4 faults spaced past each restore → the 4th sets fail_o=1 and core_rst_no=0 permanently. rst_i clears fail_o and all counters.
